dispatch: RTL and testbench

DISPATCH -- requirements
Module: dispatch

---
 rtl/dispatch_if.sv | 28 ++
 rtl/dispatch.sv | 170 +++++++++++++++++
 tb/tb_dispatch.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_if.sv
// Fetch-to-dispatch and dispatch-to-issue-queue bundle.
// The slave modport is the dispatch stage's view; the master modport is
// the view of whatever drives fetch and consumes the issue_queue pushes.
// ELEM_W is the packed width of one issue_queue element:
// {pc[31:0], op[4:0], src0[4:0], src1[4:0], dst[4:0], imm[31:0]}.
interface dispatch_if #(
  parameter int IQ_ADDR = 4
);
  localparam int ELEM_W = 84;

  logic [1:0]                   fetch_valid;
  logic [1:0][31:0]             fetch_inst;
  logic [1:0][31:0]             fetch_pc;
  logic                         fetch_ready;
  logic [IQ_ADDR-1:0]           size_left;
  logic [1:0][ELEM_W-1:0]       in_data;
  logic [1:0]                   in_data_number;

  modport slave (
    input  fetch_valid, fetch_inst, fetch_pc, size_left,
    output fetch_ready, in_data, in_data_number
  );

  modport master (
    output fetch_valid, fetch_inst, fetch_pc, size_left,
    input  fetch_ready, in_data, in_data_number
  );
endinterface

// File: rtl/dispatch.sv
// Dispatch stage: decodes up to two MIPS instructions per cycle into a
// circular buffer of DEPTH entries and pushes up to two of them per cycle
// into the issue queue, limited by the free space it reports.
module dispatch #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  dispatch_if.slave bus
);

  localparam int             PW      = $clog2(DEPTH);
  localparam logic [PW:0]    L_DEPTH = (PW+1)'(DEPTH);

  // Internal op encoding carried in the issue_queue element.
  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADDU  = 5'd1;
  localparam logic [4:0] OP_SUBU  = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_ADDIU = 5'd9;
  localparam logic [4:0] OP_SLTI  = 5'd10;
  localparam logic [4:0] OP_ANDI  = 5'd11;
  localparam logic [4:0] OP_ORI   = 5'd12;
  localparam logic [4:0] OP_XORI  = 5'd13;
  localparam logic [4:0] OP_LUI   = 5'd14;
  localparam logic [4:0] OP_LW    = 5'd15;
  localparam logic [4:0] OP_SW    = 5'd16;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  op;
    logic [4:0]  src0;
    logic [4:0]  src1;
    logic [4:0]  dst;
    logic [31:0] imm;
  } iq_elem_t;

  // Decode one raw instruction word into a buffer entry. Anything not
  // recognised becomes a NOP with all register fields zero.
  function automatic iq_elem_t decode(input logic [31:0] inst, input logic [31:0] pc);
    iq_elem_t e;
    e    = '0;
    e.pc = pc;
    case (inst[31:26])
      6'h00: begin
        e.src0 = inst[25:21];
        e.src1 = inst[20:16];
        e.dst  = inst[15:11];
        case (inst[5:0])
          6'h21:   e.op = OP_ADDU;
          6'h23:   e.op = OP_SUBU;
          6'h24:   e.op = OP_AND;
          6'h25:   e.op = OP_OR;
          6'h26:   e.op = OP_XOR;
          6'h2A:   e.op = OP_SLT;
          default: e.op = OP_NOP;
        endcase
      end
      6'h09, 6'h0A: begin
        e.op   = (inst[31:26] == 6'h09) ? OP_ADDIU : OP_SLTI;
        e.src0 = inst[25:21];
        e.dst  = inst[20:16];
        e.imm  = {{16{inst[15]}}, inst[15:0]};
      end
      6'h0C, 6'h0D, 6'h0E: begin
        e.op   = (inst[31:26] == 6'h0C) ? OP_ANDI :
                 (inst[31:26] == 6'h0D) ? OP_ORI  : OP_XORI;
        e.src0 = inst[25:21];
        e.dst  = inst[20:16];
        e.imm  = {16'h0000, inst[15:0]};
      end
      6'h0F: begin
        e.op   = OP_LUI;
        e.dst  = inst[20:16];
        e.imm  = {inst[15:0], 16'h0000};
      end
      6'h23: begin
        e.op   = OP_LW;
        e.src0 = inst[25:21];
        e.dst  = inst[20:16];
        e.imm  = {{16{inst[15]}}, inst[15:0]};
      end
      6'h2B: begin
        e.op   = OP_SW;
        e.src0 = inst[25:21];
        e.src1 = inst[20:16];
        e.imm  = {{16{inst[15]}}, inst[15:0]};
      end
      default: e.op = OP_NOP;
    endcase
    return e;
  endfunction

  iq_elem_t        r_buf [DEPTH];
  logic [PW-1:0]   r_rptr;
  logic [PW-1:0]   r_wptr;
  logic [PW:0]     r_count;

  logic [PW:0]     w_free;
  logic            w_fetch_ready;
  logic            w_accept;
  logic [1:0]      w_acc_n;
  logic [1:0]      w_num;
  logic [1:0]      w_we;
  logic [PW-1:0]   w_wr_idx [2];
  logic [PW-1:0]   w_rd_idx [2];
  iq_elem_t        w_dec    [2];

  // Intake only when two slots are guaranteed free, judged from the
  // registered count so a same-cycle push never feeds back into ready.
  // Ready is also forced low while reset is held.
  assign w_free        = L_DEPTH - r_count;
  assign w_fetch_ready = rst_n & ~flush & (w_free >= (PW+1)'(2));
  assign w_accept      = w_fetch_ready & bus.fetch_valid[0];
  assign w_acc_n       = !w_accept ? 2'd0 : (bus.fetch_valid[1] ? 2'd2 : 2'd1);

  assign bus.fetch_ready    = w_fetch_ready;
  assign bus.in_data_number = w_num;

  // Per-slot decode, write addressing and read-out of the two oldest entries.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign w_dec[gi]       = decode(bus.fetch_inst[gi], bus.fetch_pc[gi]);
    assign w_we[gi]        = w_accept & bus.fetch_valid[gi];
    assign w_wr_idx[gi]    = r_wptr + PW'(gi);
    assign w_rd_idx[gi]    = r_rptr + PW'(gi);
    assign bus.in_data[gi] = r_buf[w_rd_idx[gi]];
  end

  // Push count: min(count, 2, size_left), nothing while flushing.
  always_comb begin
    w_num = 2'd0;
    if (!flush) begin
      w_num = (r_count >= (PW+1)'(2)) ? 2'd2 : r_count[1:0];
      if (int'(bus.size_left) < int'(w_num)) begin
        w_num = bus.size_left[1:0];
      end
    end
  end

  // Buffer storage; contents are left untouched by reset and flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_we[i]) begin
        r_buf[w_wr_idx[i]] <= w_dec[i];
      end
    end
  end

  // Pointer and occupancy bookkeeping; flush and reset both empty the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(w_acc_n);
      r_rptr  <= r_rptr + PW'(w_num);
      r_count <= r_count + (PW+1)'(w_acc_n) - (PW+1)'(w_num);
    end
  end

endmodule

// File: tb/tb_dispatch.sv
// Directed bench for dispatch: a vector table for decode and back-pressure,
// then hand-written sequences for wrap-around ordering, flush and
// asynchronous reset.
module tb_dispatch;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  op;
    logic [4:0]  src0;
    logic [4:0]  src1;
    logic [4:0]  dst;
    logic [31:0] imm;
  } elem_t;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADDU  = 5'd1;
  localparam logic [4:0] OP_ADDIU = 5'd9;
  localparam logic [4:0] OP_ORI   = 5'd12;
  localparam logic [4:0] OP_LUI   = 5'd14;
  localparam logic [4:0] OP_LW    = 5'd15;
  localparam logic [4:0] OP_SW    = 5'd16;

  localparam logic [31:0] I_ADDIU = 32'h2422FFFF; // addiu $2,$1,-1
  localparam logic [31:0] I_ORI   = 32'h34438000; // ori   $3,$2,0x8000
  localparam logic [31:0] I_ADDU  = 32'h00A62021; // addu  $4,$5,$6
  localparam logic [31:0] I_LUI   = 32'h3C071234; // lui   $7,0x1234
  localparam logic [31:0] I_LW    = 32'h8D28FFFC; // lw    $8,-4($9)
  localparam logic [31:0] I_SW    = 32'hAD6A0010; // sw    $10,16($11)
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF; // opcode 0x3F

  typedef struct {
    logic [1:0]  fv;
    logic [31:0] i0, i1, p0, p1;
    logic [3:0]  sl;
    logic        fl;
    logic        e_rdy;
    logic [1:0]  e_num;
    elem_t       e0, e1;
  } vec_t;

  localparam int NV = 14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  dispatch_if #(.IQ_ADDR(4)) bus();

  dispatch #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic elem_t el(input logic [31:0] pc, input logic [4:0] op,
                               input logic [4:0] s0, input logic [4:0] s1,
                               input logic [4:0] d, input logic [31:0] imm);
    elem_t e;
    e.pc = pc; e.op = op; e.src0 = s0; e.src1 = s1; e.dst = d; e.imm = imm;
    return e;
  endfunction

  function automatic elem_t addu_at(input logic [31:0] pc);
    return el(pc, OP_ADDU, 5'd5, 5'd6, 5'd4, 32'h0);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present inputs after the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input logic [3:0] sl, input logic fl);
    @(negedge clk);
    bus.fetch_valid   = fv;
    bus.fetch_inst[0] = i0;
    bus.fetch_inst[1] = i1;
    bus.fetch_pc[0]   = p0;
    bus.fetch_pc[1]   = p1;
    bus.size_left     = sl;
    flush             = fl;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  vec_t          vt [NV];
  elem_t         z;
  elem_t         got0;
  logic [31:0]   pcq [$];
  logic [31:0]   pc_n;
  logic [1:0]    fv;
  int            cnt_m;
  logic          exp_rdy;
  logic [1:0]    exp_num;

  initial begin
    z = '0;
    vt[0]  = '{2'b11, I_ADDIU, I_ORI, 32'h100, 32'h104, 4'd8, 1'b0, 1'b1, 2'd0, z, z};
    vt[1]  = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd8, 1'b0, 1'b1, 2'd2,
               el(32'h100, OP_ADDIU, 5'd1, 5'd0, 5'd2, 32'hFFFFFFFF),
               el(32'h104, OP_ORI,   5'd2, 5'd0, 5'd3, 32'h00008000)};
    vt[2]  = '{2'b11, I_ADDU, I_LUI, 32'h200, 32'h204, 4'd8, 1'b0, 1'b1, 2'd0, z, z};
    vt[3]  = '{2'b11, I_LW, I_SW, 32'h208, 32'h20C, 4'd2, 1'b0, 1'b1, 2'd2,
               addu_at(32'h200),
               el(32'h204, OP_LUI, 5'd0, 5'd0, 5'd7, 32'h12340000)};
    vt[4]  = '{2'b01, I_BAD, I_ADDU, 32'h210, 32'h0, 4'd1, 1'b0, 1'b1, 2'd1,
               el(32'h208, OP_LW, 5'd9, 5'd0, 5'd8, 32'hFFFFFFFC), z};
    vt[5]  = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd8, 1'b0, 1'b1, 2'd2,
               el(32'h20C, OP_SW, 5'd11, 5'd10, 5'd0, 32'h00000010),
               el(32'h210, OP_NOP, 5'd0, 5'd0, 5'd0, 32'h0)};
    vt[6]  = '{2'b11, I_ADDU, I_ADDU, 32'h300, 32'h304, 4'd0, 1'b0, 1'b1, 2'd0, z, z};
    vt[7]  = '{2'b11, I_ADDU, I_ADDU, 32'h308, 32'h30C, 4'd0, 1'b0, 1'b1, 2'd0, z, z};
    vt[8]  = '{2'b11, I_ADDU, I_ADDU, 32'h310, 32'h314, 4'd0, 1'b0, 1'b0, 2'd0, z, z};
    vt[9]  = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd1, 1'b0, 1'b0, 2'd1, addu_at(32'h300), z};
    vt[10] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd1, 1'b0, 1'b0, 2'd1, addu_at(32'h304), z};
    vt[11] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd1, 1'b0, 1'b1, 2'd1, addu_at(32'h308), z};
    vt[12] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd1, 1'b0, 1'b1, 2'd1, addu_at(32'h30C), z};
    vt[13] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd1, 1'b0, 1'b1, 2'd0, z, z};

    bus.fetch_valid = 2'b00;
    bus.fetch_inst  = '0;
    bus.fetch_pc    = '0;
    bus.size_left   = 4'd0;

    // Held in reset with a valid pair offered: nothing may be accepted.
    drive(2'b11, I_ADDIU, I_ORI, 32'h40, 32'h44, 4'd8, 1'b0);
    chk("reset_ready", bus.fetch_ready, 1'b0);
    chk("reset_num", bus.in_data_number, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.fetch_valid = 2'b00;
    #1;
    chk("post_reset_ready", bus.fetch_ready, 1'b1);
    chk("post_reset_num", bus.in_data_number, 2'd0);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].fv, vt[i].i0, vt[i].i1, vt[i].p0, vt[i].p1, vt[i].sl, vt[i].fl);
      $display("vec %0d: valid=%b size_left=%0d ready=%0b num=%0d", i, vt[i].fv, vt[i].sl,
               bus.fetch_ready, bus.in_data_number);
      chk($sformatf("vec%0d_ready", i), bus.fetch_ready, vt[i].e_rdy);
      chk($sformatf("vec%0d_num", i), bus.in_data_number, vt[i].e_num);
      if (vt[i].e_num >= 2'd1) chk($sformatf("vec%0d_elem0", i), bus.in_data[0], vt[i].e0);
      if (vt[i].e_num == 2'd2) chk($sformatf("vec%0d_elem1", i), bus.in_data[1], vt[i].e1);
    end

    // Alternating single/pair fetch against a one-per-cycle issue queue.
    cnt_m = 0;
    pc_n  = 32'h1000;
    for (int c = 0; c < 28; c++) begin
      fv = (c >= 20) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b11);
      drive(fv, I_ADDU, I_ADDU, pc_n, pc_n + 32'd4, 4'd1, 1'b0);
      exp_rdy = ((4 - cnt_m) >= 2);
      exp_num = (cnt_m > 0) ? 2'd1 : 2'd0;
      got0 = bus.in_data[0];
      $display("order %0d: valid=%b ready=%0b num=%0d pc0=%h", c, fv, bus.fetch_ready,
               bus.in_data_number, got0.pc);
      chk($sformatf("order%0d_ready", c), bus.fetch_ready, exp_rdy);
      chk($sformatf("order%0d_num", c), bus.in_data_number, exp_num);
      if (exp_num == 2'd1) begin
        chk($sformatf("order%0d_pc", c), got0.pc, pcq[0]);
        void'(pcq.pop_front());
      end
      if (exp_rdy && fv[0]) begin
        pcq.push_back(pc_n);
        if (fv[1]) pcq.push_back(pc_n + 32'd4);
        pc_n = pc_n + (fv[1] ? 32'd8 : 32'd4);
      end
      cnt_m = pcq.size();
    end

    // Flush with three entries buffered and a pair on the fetch side.
    drive(2'b11, I_ADDU, I_ADDU, 32'h2000, 32'h2004, 4'd0, 1'b0);
    chk("fl_fill0_ready", bus.fetch_ready, 1'b1);
    drive(2'b01, I_ADDU, I_ADDU, 32'h2008, 32'h0, 4'd0, 1'b0);
    chk("fl_fill1_ready", bus.fetch_ready, 1'b1);
    drive(2'b11, I_ADDU, I_ADDU, 32'h3000, 32'h3004, 4'd8, 1'b1);
    $display("flush: ready=%0b num=%0d", bus.fetch_ready, bus.in_data_number);
    chk("fl_num", bus.in_data_number, 2'd0);
    chk("fl_ready", bus.fetch_ready, 1'b0);
    drive(2'b11, I_ADDU, I_ADDU, 32'h4000, 32'h4004, 4'd8, 1'b0);
    chk("fl_after_num", bus.in_data_number, 2'd0);
    chk("fl_after_ready", bus.fetch_ready, 1'b1);
    drive(2'b00, I_ADDU, I_ADDU, 32'h0, 32'h0, 4'd8, 1'b0);
    chk("fl_fresh_num", bus.in_data_number, 2'd2);
    chk("fl_fresh_elem0", bus.in_data[0], addu_at(32'h4000));
    chk("fl_fresh_elem1", bus.in_data[1], addu_at(32'h4004));

    // Asynchronous reset mid-cycle with three entries buffered.
    drive(2'b11, I_ADDU, I_ADDU, 32'h5000, 32'h5004, 4'd0, 1'b0);
    chk("ar_fill0_ready", bus.fetch_ready, 1'b1);
    drive(2'b01, I_ADDU, I_ADDU, 32'h5008, 32'h0, 4'd0, 1'b0);
    chk("ar_fill1_ready", bus.fetch_ready, 1'b1);
    drive(2'b00, I_ADDU, I_ADDU, 32'h0, 32'h0, 4'd8, 1'b0);
    chk("ar_pre_num", bus.in_data_number, 2'd2);
    chk("ar_pre_elem0", bus.in_data[0], addu_at(32'h5000));
    #1 rst_n = 1'b0;
    #1;
    $display("async reset: ready=%0b num=%0d", bus.fetch_ready, bus.in_data_number);
    chk("ar_now_num", bus.in_data_number, 2'd0);
    chk("ar_now_ready", bus.fetch_ready, 1'b0);
    drive(2'b00, I_ADDU, I_ADDU, 32'h0, 32'h0, 4'd8, 1'b0);
    chk("ar_hold_num", bus.in_data_number, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_release_ready", bus.fetch_ready, 1'b1);
    chk("ar_release_num", bus.in_data_number, 2'd0);
    drive(2'b00, I_ADDU, I_ADDU, 32'h0, 32'h0, 4'd8, 1'b0);
    chk("ar_later_num", bus.in_data_number, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
